// File: rtl/counter_sequencer.sv
// Run controller for a load/enable/clear up/down counter: accepts START/STOP/PAUSE/CLEAR
// commands over a valid/ready port and sequences one or more start->terminal runs.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int RW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a command transfers on the rising edge where cmd_valid & cmd_ready are both 1;
  // cmd_ready depends only on state, never on cmd_valid.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_term,
  input  logic             cmd_up,
  input  logic [RW-1:0]    cmd_reps,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RW-1:0]    reps_left,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_start, w_start_n;
  logic [WIDTH-1:0] r_term, w_term_n;
  logic             r_up, w_up_n;
  logic [RW-1:0]    r_reps, w_reps_n;
  logic             r_done, r_err, r_clr, r_busy;
  logic             w_done_n, w_err_n, w_clr_n;
  logic             w_accept, w_at_term;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_at_term = (cnt_value == r_term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_term  <= '0;
      r_up    <= 1'b0;
      r_reps  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_start_n;
      r_term  <= w_term_n;
      r_up    <= w_up_n;
      r_reps  <= w_reps_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_clr   <= w_clr_n;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start_n = r_start;
    w_term_n  = r_term;
    w_up_n    = r_up;
    w_reps_n  = r_reps;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_clr_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_START: begin
              w_start_n = cmd_start;
              w_term_n  = cmd_term;
              w_up_n    = cmd_up;
              w_reps_n  = cmd_reps;
              w_next    = S_LOAD;
            end
            OP_CLEAR: w_clr_n = 1'b1;
            default:  w_err_n = 1'b1;
          endcase
        end
      end
      S_LOAD: w_next = S_RUN;
      S_RUN, S_HOLD: begin
        // An accepted command outranks terminal handling in the same cycle.
        if (w_accept) begin
          case (cmd_op)
            OP_PAUSE: w_next = (r_state == S_RUN) ? S_HOLD : S_RUN;
            OP_STOP:  w_next = S_IDLE;
            OP_CLEAR: begin
              w_next   = S_IDLE;
              w_clr_n  = 1'b1;
              w_reps_n = '0;
            end
            default:  w_err_n = 1'b1;
          endcase
        end else if (r_state == S_RUN && w_at_term) begin
          if (r_reps == RW'(1)) begin
            w_next   = S_IDLE;
            w_done_n = 1'b1;
            w_reps_n = '0;
          end else begin
            // reps of zero means free-run: reload forever without counting down.
            if (r_reps != '0) w_reps_n = r_reps - RW'(1);
            w_next = S_LOAD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cmd_ready    = (r_state != S_LOAD);
  assign cnt_load     = (r_state == S_LOAD);
  assign cnt_load_val = r_start;
  assign cnt_en       = (r_state == S_RUN) && !w_at_term;
  assign cnt_up       = r_up;
  assign cnt_clr      = r_clr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign reps_left    = r_reps;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit load/enable/clear counter
// closing the loop on cnt_value.
module tb_counter_sequencer;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_start = 4'd0;
  logic [3:0] cmd_term = 4'd0;
  logic       cmd_up = 1'b0;
  logic [3:0] cmd_reps = 4'd0;
  logic [3:0] cnt_value;
  logic       cnt_load, cnt_en, cnt_up, cnt_clr, busy, done, err;
  logic [3:0] cnt_load_val, reps_left;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int en_cnt, load_cnt, done_cnt, err_cnt;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_clr = 1'b0;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  counter_sequencer #(.WIDTH(4), .RW(4)) dut (
    .clk(clk), .rst(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_start(cmd_start), .cmd_term(cmd_term), .cmd_up(cmd_up), .cmd_reps(cmd_reps),
    .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .cnt_clr(cnt_clr), .busy(busy), .done(done), .err(err),
    .reps_left(reps_left), .dbg_state(dbg_state)
  );

  // clock / reset and the counter datapath being controlled
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_value <= 4'd0;
    else if (cnt_clr) cnt_value <= 4'd0;
    else if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 4'd1 : cnt_value - 4'd1;
  end

  // pulse counting and RUN-cycle value log
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_en) en_cnt++;
      if (cnt_load) load_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (dbg_state == S_RUN) got_q.push_back(cnt_value);
      if (done || err || cnt_clr) begin
        checks++;
        if ((done && prev_done) || (err && prev_err) || (cnt_clr && prev_clr)) begin
          errors++;
          $display("FAIL pulse_width: done=%0b err=%0b clr=%0b high two cycles running", done, err, cnt_clr);
        end
      end
    end
    prev_done = done;
    prev_err  = err;
    prev_clr  = cnt_clr;
  end

  // driver tasks
  task automatic clear_counts();
    en_cnt = 0; load_cnt = 0; done_cnt = 0; err_cnt = 0;
    got_q.delete();
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] st, input logic [3:0] tm,
                           input logic up, input logic [3:0] reps);
    cmd_valid = 1'b1; cmd_op = op; cmd_start = st; cmd_term = tm; cmd_up = up; cmd_reps = reps;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_run_value(input logic [3:0] v, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == S_RUN && cnt_value == v) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cnt_load, cnt_en, cnt_up, cnt_clr, busy, done, err} !== 7'd0 || reps_left !== 4'd0
        || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: load/en/up/clr/busy/done/err=%b reps=%0d ready=%b, required 0000000/0/1",
               {cnt_load, cnt_en, cnt_up, cnt_clr, busy, done, err}, reps_left, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d busy=%b, required 0/0", dbg_state, busy);
    end
  endtask

  task automatic test_single_run();
    bit ok;
    @(negedge clk); #1 clear_counts();
    drive_cmd(OP_START, 4'd2, 4'd5, 1'b1, 4'd1);
    @(negedge clk);
    checks++;
    if (cnt_load !== 1'b1 || cnt_load_val !== 4'd2 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load: load=%b val=%0d ready=%b busy=%b, required 1/2/0/1",
               cnt_load, cnt_load_val, cmd_ready, busy);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL single_done_with_busy: idle_seen=%b done=%b, required 1/1", ok, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (en_cnt != 3 || load_cnt != 1 || done_cnt != 1 || cnt_value !== 4'd5 || reps_left !== 4'd0) begin
      errors++;
      $display("FAIL single_counts: en=%0d load=%0d done=%0d value=%0d reps=%0d, required 3/1/1/5/0",
               en_cnt, load_cnt, done_cnt, cnt_value, reps_left);
    end
  endtask

  task automatic test_wrap_reps();
    bit ok;
    int loads;
    @(negedge clk); #1 clear_counts();
    exp_q = {4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1};
    drive_cmd(OP_START, 4'd14, 4'd1, 1'b1, 4'd2);
    @(negedge clk);
    checks++;
    if (reps_left !== 4'd2) begin
      errors++;
      $display("FAIL wrap_reps_first: reps_left=%0d, required 2", reps_left);
    end
    loads = 1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cnt_load) begin loads++; ok = 1'b1; end
    end
    checks++;
    if (!ok || reps_left !== 4'd1) begin
      errors++;
      $display("FAIL wrap_reps_second: reload_seen=%b reps_left=%0d, required 1/1", ok, reps_left);
    end
    wait_idle(20, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || en_cnt != 6 || load_cnt != 2 || done_cnt != 1 || reps_left !== 4'd0 || cnt_value !== 4'd1) begin
      errors++;
      $display("FAIL wrap_counts: idle=%b en=%0d load=%0d done=%0d reps=%0d value=%0d, required 1/6/2/1/0/1",
               ok, en_cnt, load_cnt, done_cnt, reps_left, cnt_value);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_seq_len: got %0d RUN cycles, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_seq[%0d]: got %0d, required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_eq_term();
    logic [2:0] seen;
    @(negedge clk); #1 clear_counts();
    drive_cmd(OP_START, 4'd5, 4'd5, 1'b0, 4'd1);
    @(negedge clk); seen[0] = done;
    checks++;
    if (cnt_up !== 1'b0) begin
      errors++;
      $display("FAIL eq_dir: cnt_up=%b, required 0", cnt_up);
    end
    @(negedge clk); seen[1] = done;
    @(negedge clk); seen[2] = done;
    repeat (2) @(negedge clk);
    checks++;
    if (seen !== 3'b100 || en_cnt != 0 || done_cnt != 1 || cnt_value !== 4'd5) begin
      errors++;
      $display("FAIL eq_timing: done N+3..N+1=%b en=%0d done_cnt=%0d value=%0d, required 100/0/1/5",
               seen, en_cnt, done_cnt, cnt_value);
    end
  endtask

  task automatic test_pause_stop();
    bit ok;
    bit held;
    @(negedge clk); #1 clear_counts();
    drive_cmd(OP_START, 4'd0, 4'd9, 1'b1, 4'd1);
    wait_run_value(4'd3, 20, ok);
    drive_cmd(OP_PAUSE, 4'd0, 4'd0, 1'b0, 4'd0);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cnt_en !== 1'b0 || cnt_value !== 4'd4 || dbg_state !== S_HOLD || busy !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!ok || !held) begin
      errors++;
      $display("FAIL pause_hold: reached=%b held=%b value=%0d state=%0d, required 1/1/4/3",
               ok, held, cnt_value, dbg_state);
    end
    drive_cmd(OP_PAUSE, 4'd0, 4'd0, 1'b0, 4'd0);
    wait_idle(30, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || done_cnt != 1 || en_cnt != 9 || cnt_value !== 4'd9) begin
      errors++;
      $display("FAIL pause_resume: idle=%b done=%0d en=%0d value=%0d, required 1/1/9/9",
               ok, done_cnt, en_cnt, cnt_value);
    end
    #1 clear_counts();
    drive_cmd(OP_START, 4'd0, 4'd9, 1'b1, 4'd1);
    wait_run_value(4'd5, 20, ok);
    drive_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if (!ok || dbg_state !== S_IDLE || busy !== 1'b0 || cnt_value !== 4'd6 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: reached=%b state=%0d busy=%b value=%0d en=%b, required 1/0/0/6/0",
               ok, dbg_state, busy, cnt_value, cnt_en);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL stop_no_done: done pulses=%0d, required 0", done_cnt);
    end
  endtask

  task automatic test_free_run();
    bit ok;
    int loads;
    @(negedge clk); #1 clear_counts();
    drive_cmd(OP_START, 4'd3, 4'd6, 1'b1, 4'd0);
    loads = 0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (cnt_load) loads++;
      if (loads == 5) ok = 1'b1;
    end
    checks++;
    if (!ok || done_cnt != 0 || reps_left !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL free_run: fifth_load=%b done=%0d reps=%0d busy=%b, required 1/0/0/1",
               ok, done_cnt, reps_left, busy);
    end
    wait_run_value(4'd4, 10, ok);
    drive_cmd(OP_START, 4'd0, 4'd15, 1'b0, 4'd1);
    @(negedge clk);
    checks++;
    if (!ok || err !== 1'b1 || cnt_value !== 4'd5 || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL busy_start_err: reached=%b err=%b value=%0d state=%0d, required 1/1/5/2",
               ok, err, cnt_value, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cnt_value !== 4'd6) begin
      errors++;
      $display("FAIL busy_start_err_clear: err=%b value=%0d, required 0/6", err, cnt_value);
    end
    @(negedge clk);
    checks++;
    if (cnt_load !== 1'b1 || cnt_load_val !== 4'd3 || cnt_up !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_no_effect: load=%b val=%0d up=%b, required 1/3/1", cnt_load, cnt_load_val, cnt_up);
    end
    wait_run_value(4'd4, 10, ok);
    drive_cmd(OP_CLEAR, 4'd0, 4'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if (!ok || cnt_clr !== 1'b1 || busy !== 1'b0 || dbg_state !== S_IDLE || reps_left !== 4'd0) begin
      errors++;
      $display("FAIL run_clear: reached=%b clr=%b busy=%b state=%0d reps=%0d, required 1/1/0/0/0",
               ok, cnt_clr, busy, dbg_state, reps_left);
    end
    @(negedge clk);
    checks++;
    if (cnt_clr !== 1'b0 || cnt_value !== 4'd0 || err_cnt != 1 || done_cnt != 0) begin
      errors++;
      $display("FAIL run_clear_after: clr=%b value=%0d err=%0d done=%0d, required 0/0/1/0",
               cnt_clr, cnt_value, err_cnt, done_cnt);
    end
  endtask

  task automatic test_idle_cmds();
    logic [1:0] ops[3];
    ops[0] = OP_STOP; ops[1] = OP_PAUSE; ops[2] = OP_CLEAR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_cmd(ops[i], 4'd7, 4'd7, 1'b1, 4'd3);
      @(negedge clk);
      checks++;
      if (err !== (i < 2) || cnt_clr !== (i == 2) || busy !== 1'b0 || reps_left !== 4'd0) begin
        errors++;
        $display("FAIL idle_cmd op=%0d: err=%b clr=%b busy=%b reps=%0d, required %b/%b/0/0",
                 ops[i], err, cnt_clr, busy, reps_left, (i < 2), (i == 2));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    @(negedge clk); #1 clear_counts();
    drive_cmd(OP_START, 4'd0, 4'd9, 1'b1, 4'd1);
    wait_run_value(4'd3, 20, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {cnt_load, cnt_en, cnt_up, cnt_clr, busy, done, err} !== 7'd0 || reps_left !== 4'd0
        || cnt_load_val !== 4'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: reached=%b outs=%b reps=%0d val=%0d ready=%b, required 1/0000000/0/0/1",
               ok, {cnt_load, cnt_en, cnt_up, cnt_clr, busy, done, err}, reps_left, cnt_load_val, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_done: done=%0d busy=%b ready=%b, required 0/0/1", done_cnt, busy, cmd_ready);
    end
    test_single_run();
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_wrap_reps();
    test_start_eq_term();
    test_pause_stop();
    test_free_run();
    test_idle_cmds();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
